// File: rtl/mc_controller_ws_pkg.sv
// Shared definitions for the multicycle MIPS controller with memory wait states.
// Holds the opcode and funct values, the FSM state encoding, the ALU operation
// classes and the 3-bit ALU control codes. It has no ports.
package mc_controller_ws_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // ALU control codes
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpImm   = 2'b11   // and/or chosen by opcode (andi/ori), add otherwise
    } aluop_e;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StImmWb   = 4'd10,
        StJEx     = 4'd11,
        StBneEx   = 4'd12,
        StAndiEx  = 4'd13,
        StOriEx   = 4'd14,
        StTrap    = 4'd15
    } state_e;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder for the multicycle MIPS controller.
// Ports:
//   aluop_i      - operation class requested by the main FSM
//   funct_i      - R-type funct field
//   op_i         - opcode, selects and/or for immediate logic ops
//   alucontrol_o - ALU control code, 3-bit code zero-filled to ALUCTL_W
//   funct_ok_o   - funct_i is a supported R-type function (independent of aluop_i)
module mc_aludec
    import mc_controller_ws_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 3
) (
    input  aluop_e              aluop_i,
    input  logic [5:0]          funct_i,
    input  logic [5:0]          op_i,
    output logic [ALUCTL_W-1:0] alucontrol_o,
    output logic                funct_ok_o
);

    logic [2:0] funct_code;
    logic [2:0] code;

    // Unknown (including X) funct falls to default and is reported as not ok.
    always_comb begin
        funct_ok_o = 1'b1;
        funct_code = AluAdd;
        case (funct_i)
            FnAdd:   funct_code = AluAdd;
            FnSub:   funct_code = AluSub;
            FnAnd:   funct_code = AluAnd;
            FnOr:    funct_code = AluOr;
            FnSlt:   funct_code = AluSlt;
            default: funct_ok_o = 1'b0;
        endcase
    end

    always_comb begin
        code = AluAdd;
        case (aluop_i)
            AluOpAdd:   code = AluAdd;
            AluOpSub:   code = AluSub;
            AluOpFunct: code = funct_code;
            AluOpImm: begin
                if (op_i == OpAndi) begin
                    code = AluAnd;
                end else if (op_i == OpOri) begin
                    code = AluOr;
                end else begin
                    code = AluAdd;
                end
            end
            default:    code = AluAdd;
        endcase
    end

    assign alucontrol_o = ALUCTL_W'(code);

endmodule

// File: rtl/mc_controller_ws.sv
// Multicycle MIPS control unit with memory wait states, bne/andi/ori and an
// illegal-instruction trap.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   op_i, funct_i        - instruction fields from the instruction register
//   zero_i               - ALU zero flag (branch resolution)
//   mem_ready_i          - memory completes the current access this cycle
//   pcen_o .. pcsrc_o    - datapath/memory controls
//   alucontrol_o         - ALU control code, ALUCTL_W bits
//   state_o              - current FSM state (debug)
//   illegal_o            - illegal instruction flag
module mc_controller_ws
    import mc_controller_ws_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 3,
    parameter bit          WAIT_EN  = 1'b1,
    parameter bit          EXT_OPS  = 1'b1,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [5:0]          op_i,
    input  logic [5:0]          funct_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pcen_o,
    output logic                memwrite_o,
    output logic                memread_o,
    output logic                irwrite_o,
    output logic                regwrite_o,
    output logic                alusrca_o,
    output logic                iord_o,
    output logic                memtoreg_o,
    output logic                regdst_o,
    output logic                zeroext_o,
    output logic [1:0]          alusrcb_o,
    output logic [1:0]          pcsrc_o,
    output logic [ALUCTL_W-1:0] alucontrol_o,
    output logic [3:0]          state_o,
    output logic                illegal_o
);

    state_e state_q, state_d;
    state_e dec_next;
    logic   dec_illegal;
    logic   mem_ok;
    logic   funct_ok;
    aluop_e aluop;
    logic   alu_en;
    logic   pcwrite, branch, bne;
    logic [ALUCTL_W-1:0] alu_code;

    assign mem_ok = WAIT_EN ? mem_ready_i : 1'b1;

    mc_aludec #(
        .ALUCTL_W(ALUCTL_W)
    ) u_aludec (
        .aluop_i     (aluop),
        .funct_i     (funct_i),
        .op_i        (op_i),
        .alucontrol_o(alu_code),
        .funct_ok_o  (funct_ok)
    );

    // Instruction decode, only consumed in StDecode.
    always_comb begin
        dec_next    = StFetch;
        dec_illegal = 1'b0;
        case (op_i)
            OpLw, OpSw: dec_next = StMemAdr;
            OpRtype: begin
                if (funct_ok) dec_next = StRtypeEx;
                else          dec_illegal = 1'b1;
            end
            OpBeq:      dec_next = StBeqEx;
            OpAddi:     dec_next = StAddiEx;
            OpJ:        dec_next = StJEx;
            OpBne: begin
                if (EXT_OPS) dec_next = StBneEx;
                else         dec_illegal = 1'b1;
            end
            OpAndi: begin
                if (EXT_OPS) dec_next = StAndiEx;
                else         dec_illegal = 1'b1;
            end
            OpOri: begin
                if (EXT_OPS) dec_next = StOriEx;
                else         dec_illegal = 1'b1;
            end
            default:    dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_next = TRAP_EN ? StTrap : StFetch;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (mem_ok) state_d = StDecode;
            StDecode:  state_d = dec_next;
            StMemAdr:  state_d = (op_i == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ok) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (mem_ok) state_d = StFetch;
            StRtypeEx: state_d = StRtypeWb;
            StRtypeWb: state_d = StFetch;
            StBeqEx, StBneEx, StJEx, StImmWb: state_d = StFetch;
            StAddiEx, StAndiEx, StOriEx:      state_d = StImmWb;
            StTrap:    state_d = StTrap;
            default:   state_d = StFetch;
        endcase
    end

    // Outputs
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        memwrite_o = 1'b0;
        memread_o  = 1'b0;
        irwrite_o  = 1'b0;
        regwrite_o = 1'b0;
        alusrca_o  = 1'b0;
        iord_o     = 1'b0;
        memtoreg_o = 1'b0;
        regdst_o   = 1'b0;
        zeroext_o  = 1'b0;
        alusrcb_o  = 2'b00;
        pcsrc_o    = 2'b00;
        aluop      = AluOpAdd;
        alu_en     = 1'b0;
        case (state_q)
            StFetch: begin
                memread_o = 1'b1;
                alusrcb_o = 2'b01;
                // PC+4 is only computed and written on the accepting cycle, so the
                // whole bundle except the held request is quiet during a wait.
                irwrite_o = mem_ok;
                pcwrite   = mem_ok;
                alu_en    = mem_ok;
            end
            StDecode: begin
                alusrcb_o = 2'b11;
                alu_en    = 1'b1;
            end
            StMemAdr: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                alu_en    = 1'b1;
            end
            StMemRd: begin
                iord_o    = 1'b1;
                memread_o = 1'b1;
            end
            StMemWb: begin
                memtoreg_o = 1'b1;
                regwrite_o = 1'b1;
            end
            StMemWr: begin
                iord_o     = 1'b1;
                memwrite_o = 1'b1;
            end
            StRtypeEx: begin
                alusrca_o = 1'b1;
                aluop     = AluOpFunct;
                alu_en    = 1'b1;
            end
            StRtypeWb: begin
                regdst_o   = 1'b1;
                regwrite_o = 1'b1;
            end
            StBeqEx, StBneEx: begin
                alusrca_o = 1'b1;
                pcsrc_o   = 2'b01;
                aluop     = AluOpSub;
                alu_en    = 1'b1;
                branch    = (state_q == StBeqEx);
                bne       = (state_q == StBneEx);
            end
            StAddiEx: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                alu_en    = 1'b1;
            end
            StAndiEx, StOriEx: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                zeroext_o = 1'b1;
                aluop     = AluOpImm;
                alu_en    = 1'b1;
            end
            StImmWb: regwrite_o = 1'b1;
            StJEx: begin
                pcsrc_o = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign alucontrol_o = alu_en ? alu_code : '0;
    assign pcen_o       = pcwrite | (branch & zero_i) | (bne & ~zero_i);
    assign state_o      = state_q;
    assign illegal_o    = (state_q == StTrap) | ((state_q == StDecode) & dec_illegal);

endmodule
